// File: rtl/aidc_lite_code_bank_if.sv
// Output stream of the AIDC-Lite code bank.
// Valid/ready handshake carrying one code word per beat.
interface aidc_lite_code_bank_if #(
  parameter int ADDR_W = 4
);
  logic              m_valid_o;
  logic              m_ready_i;
  logic [63:0]       m_data_o;
  logic              m_last_o;
  logic [ADDR_W:0]   m_nwords_o;

  modport master (
    output m_valid_o,
    output m_data_o,
    output m_last_o,
    output m_nwords_o,
    input  m_ready_i
  );

  modport slave (
    input  m_valid_o,
    input  m_data_o,
    input  m_last_o,
    input  m_nwords_o,
    output m_ready_i
  );
endinterface

// File: rtl/aidc_lite_code_bank.sv
// AIDC-Lite code bank: ping-pong capture of packed code words
// and block-wise valid/ready drain to a stallable consumer.
module aidc_lite_code_bank #(
  parameter int NUM_WORDS = 16,
  parameter int ADDR_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cc_valid_i,
  input  logic [ADDR_W-1:0]     cc_addr_i,
  input  logic [63:0]           cc_data_i,
  input  logic                  cc_done_i,
  aidc_lite_code_bank_if.master m,
  output logic                  ovf_o,
  output logic                  seq_err_o
);

  typedef enum logic [1:0] {
    B_EMPTY,
    B_FILLING,
    B_FULL,
    B_DRAINING
  } bank_st_e;

  bank_st_e          st_q [2];
  bank_st_e          st_d [2];
  logic [ADDR_W:0]   nw_q [2];
  logic [ADDR_W:0]   nw_d [2];
  logic [63:0]       mem_q [2][NUM_WORDS];

  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic              drop_q, drop_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic              seq_err_q, seq_err_d;
  logic [ADDR_W-1:0] exp_addr_q, exp_addr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   m_nw_q, m_nw_d;

  logic              end_word;
  logic              wr_open;
  logic              mem_we;
  logic              last_w;
  logic              hs;

  assign end_word = cc_valid_i && cc_done_i && !done_q;
  assign wr_open  = (st_q[wr_bank_q] == B_EMPTY) ||
                    (st_q[wr_bank_q] == B_FILLING);
  assign last_w   = valid_q &&
                    ({1'b0, rd_ptr_q} == m_nw_q - (ADDR_W+1)'(1));
  assign hs       = valid_q && m.m_ready_i;

  always_comb begin
    st_d       = st_q;
    nw_d       = nw_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    drop_d     = drop_q;
    done_d     = cc_done_i;
    valid_d    = valid_q;
    ovf_d      = ovf_q;
    seq_err_d  = seq_err_q;
    exp_addr_d = exp_addr_q;
    rd_ptr_d   = rd_ptr_q;
    m_nw_d     = m_nw_q;
    mem_we     = 1'b0;

    // write side only touches EMPTY/FILLING banks, read side only
    // FULL/DRAINING, so both may update st_d in the same cycle
    if (cc_valid_i) begin
      if (drop_q) begin
        if (end_word) begin
          drop_d     = 1'b0;
          exp_addr_d = '0;
        end
      end else if (wr_open) begin
        mem_we              = 1'b1;
        st_d[wr_bank_q]     = B_FILLING;
        exp_addr_d          = exp_addr_q + ADDR_W'(1);
        if (cc_addr_i != exp_addr_q)
          seq_err_d = 1'b1;
        if (end_word) begin
          nw_d[wr_bank_q] = {1'b0, cc_addr_i} + (ADDR_W+1)'(1);
          st_d[wr_bank_q] = B_FULL;
          wr_bank_d       = ~wr_bank_q;
          exp_addr_d      = '0;
        end
      end else begin
        ovf_d = 1'b1;
        if (end_word)
          exp_addr_d = '0;
        else
          drop_d = 1'b1;
      end
    end

    if (!valid_q) begin
      if (st_q[rd_bank_q] == B_FULL) begin
        st_d[rd_bank_q] = B_DRAINING;
        valid_d         = 1'b1;
        rd_ptr_d        = '0;
        m_nw_d          = nw_q[rd_bank_q];
      end
    end else if (hs) begin
      if (last_w) begin
        st_d[rd_bank_q] = B_EMPTY;
        rd_bank_d       = ~rd_bank_q;
        valid_d         = 1'b0;
        rd_ptr_d        = '0;
      end else begin
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q[0]    <= B_EMPTY;
      st_q[1]    <= B_EMPTY;
      nw_q[0]    <= '0;
      nw_q[1]    <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      drop_q     <= 1'b0;
      done_q     <= 1'b1;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      seq_err_q  <= 1'b0;
      exp_addr_q <= '0;
      rd_ptr_q   <= '0;
      m_nw_q     <= '0;
    end else begin
      st_q       <= st_d;
      nw_q       <= nw_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      drop_q     <= drop_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      seq_err_q  <= seq_err_d;
      exp_addr_q <= exp_addr_d;
      rd_ptr_q   <= rd_ptr_d;
      m_nw_q     <= m_nw_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem_q[wr_bank_q][cc_addr_i] <= cc_data_i;
  end

  assign m.m_valid_o  = valid_q;
  assign m.m_data_o   = mem_q[rd_bank_q][rd_ptr_q];
  assign m.m_last_o   = last_w;
  assign m.m_nwords_o = m_nw_q;
  assign ovf_o        = ovf_q;
  assign seq_err_o    = seq_err_q;

endmodule
